// File: rtl/result_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : result_display_driver
// Purpose  : Sequential double-dabble BCD conversion of a 16-bit result and
//            round-robin drive of a 6-digit multiplexed 7-segment display.
// Revision : 1.0 - initial release
// ============================================================================
module result_display_driver #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] result,
    input  logic        overflow,
    input  logic        div_error,
    output logic [7:0]  seg,
    output logic [5:0]  an,
    output logic        busy,
    output logic [19:0] disp_bcd
);

    localparam int                 c_CNT_W     = $clog2(SCAN_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [7:0]         c_BLANK     = 8'hFF;
    localparam logic [7:0]         c_O         = 8'hA3;
    localparam logic [39:0]        c_ERR_CODES = {8'hFF, 8'hFF, 8'h86, 8'hAF, 8'hAF};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [17:0] r_snap;
    logic [17:0] w_in;
    logic        w_change;
    logic [19:0] r_bcd;
    logic [19:0] w_bcd_adj;
    logic [15:0] r_bin;
    logic [3:0]  r_bit_cnt;
    logic        r_busy;
    logic [19:0] r_disp_bcd;
    logic        r_disp_ovf;
    logic        r_disp_err;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_seg;
    logic [5:0]  r_an;
    logic [4:0]  w_lead_zero;
    logic [7:0]  w_code [0:5];
    logic [7:0]  w_seg_nxt;

    function automatic logic [7:0] f_seg(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    assign w_in     = {result, overflow, div_error};
    assign w_change = (w_in != r_snap);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_change) w_state_nxt = S_CONV;
            S_CONV:  if (r_bit_cnt == 4'd15) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    generate
        for (genvar i = 0; i < 5; i++) begin : g_adj
            assign w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ?
                                         r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap     <= '0;
            r_bcd      <= '0;
            r_bin      <= '0;
            r_bit_cnt  <= '0;
            r_busy     <= 1'b0;
            r_disp_bcd <= '0;
            r_disp_ovf <= 1'b0;
            r_disp_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_change) begin
                        r_snap    <= w_in;
                        r_bcd     <= '0;
                        r_bin     <= result;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_CONV: begin
                    r_bcd     <= {w_bcd_adj[18:0], r_bin[15]};
                    r_bin     <= {r_bin[14:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                S_LOAD: begin
                    r_disp_bcd <= r_bcd;
                    r_disp_ovf <= r_snap[1];
                    r_disp_err <= r_snap[0];
                    r_busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // A digit is blanked when it and every more significant digit are zero.
    generate
        for (genvar k = 0; k < 5; k++) begin : g_digit
            if (k == 0) begin : g_lsd
                assign w_lead_zero[k] = 1'b0;
            end else begin : g_upper
                assign w_lead_zero[k] = (r_disp_bcd[19:4*k] == '0);
            end
            assign w_code[k] = r_disp_err     ? c_ERR_CODES[8*k +: 8] :
                               w_lead_zero[k] ? c_BLANK :
                               f_seg(r_disp_bcd[4*k +: 4]);
        end
    endgenerate

    assign w_code[5] = (!r_disp_err && r_disp_ovf) ? c_O : c_BLANK;

    always_comb begin
        w_seg_nxt = c_BLANK;
        case (r_idx)
            3'd0:    w_seg_nxt = w_code[0];
            3'd1:    w_seg_nxt = w_code[1];
            3'd2:    w_seg_nxt = w_code[2];
            3'd3:    w_seg_nxt = w_code[3];
            3'd4:    w_seg_nxt = w_code[4];
            3'd5:    w_seg_nxt = w_code[5];
            default: w_seg_nxt = c_BLANK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_seg <= 8'hFF;
            r_an  <= 6'b111111;
        end else begin
            if (r_cnt == c_CNT_MAX) begin
                r_cnt <= '0;
                r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_seg <= w_seg_nxt;
            r_an  <= ~(6'b000001 << r_idx);
        end
    end

    assign seg      = r_seg;
    assign an       = r_an;
    assign busy     = r_busy;
    assign disp_bcd = r_disp_bcd;

endmodule
`default_nettype wire

// File: tb/tb_result_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_display_driver
// Purpose  : Directed self-checking bench for result_display_driver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_display_driver;

    logic        clk;
    logic        rst;
    logic [15:0] result;
    logic        overflow;
    logic        div_error;
    logic [7:0]  seg;
    logic [5:0]  an;
    logic        busy;
    logic [19:0] disp_bcd;

    int n_total = 0;
    int n_bad   = 0;

    result_display_driver #(.SCAN_DIV(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .result    (result),
        .overflow  (overflow),
        .div_error (div_error),
        .seg       (seg),
        .an        (an),
        .busy      (busy),
        .disp_bcd  (disp_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) until digit k is enabled, then compares its segments.
    task automatic check_digit(input string tag, input int k, input logic [7:0] exp);
        logic [5:0] want;
        bit         found;
        want  = ~(6'b000001 << k);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (an == want) found = 1'b1;
            else tick();
        end
        if (found) check(tag, seg, exp);
        else       check({tag, "_timeout"}, an, want);
    endtask

    task automatic apply_and_wait(input logic [15:0] r, input logic ov, input logic de);
        result    = r;
        overflow  = ov;
        div_error = de;
        repeat (18) tick();
    endtask

    initial begin
        logic [5:0] prev;
        bit         busy_seen;
        bit         moved;

        rst = 1'b1; result = '0; overflow = 1'b0; div_error = 1'b0;
        tick(); tick();
        check("rst_seg", seg, 8'hFF);
        check("rst_an", an, 6'b111111);
        check("rst_busy", busy, 1'b0);
        check("rst_disp", disp_bcd, 20'h0);

        rst = 1'b0;
        tick();
        check("post_rst_an", an, 6'b111110);
        check("post_rst_seg", seg, 8'hC0);
        busy_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (busy) busy_seen = 1'b1;
            tick();
        end
        check("idle_no_busy", busy_seen, 1'b0);
        for (int k = 1; k < 6; k++) check_digit("zero_blank", k, 8'hFF);

        // 12345 with exact latency
        result = 16'd12345;
        check("t2_busy_pre", busy, 1'b0);
        tick();
        check("t2_busy_rise", busy, 1'b1);
        repeat (16) tick();
        check("t2_busy_17", busy, 1'b1);
        check("t2_disp_old", disp_bcd, 20'h0);
        tick();
        check("t2_busy_fall", busy, 1'b0);
        check("t2_disp", disp_bcd, 20'h12345);
        check_digit("t2_d0", 0, 8'h92);
        check_digit("t2_d1", 1, 8'h99);
        check_digit("t2_d2", 2, 8'hB0);
        check_digit("t2_d3", 3, 8'hA4);
        check_digit("t2_d4", 4, 8'hF9);
        check_digit("t2_d5", 5, 8'hFF);

        apply_and_wait(16'd7, 1'b0, 1'b0);
        check("t3_disp", disp_bcd, 20'h00007);
        check_digit("t3_d0", 0, 8'hF8);
        for (int k = 1; k < 5; k++) check_digit("t3_blank", k, 8'hFF);

        apply_and_wait(16'd0, 1'b0, 1'b1);
        check_digit("err_d0", 0, 8'hAF);
        check_digit("err_d1", 1, 8'hAF);
        check_digit("err_d2", 2, 8'h86);
        check_digit("err_d3", 3, 8'hFF);
        check_digit("err_d4", 4, 8'hFF);
        check_digit("err_d5", 5, 8'hFF);

        apply_and_wait(16'd65535, 1'b1, 1'b0);
        check("ovf_disp", disp_bcd, 20'h65535);
        check_digit("ovf_d5", 5, 8'hA3);
        check_digit("ovf_d4", 4, 8'h82);
        check_digit("ovf_d0", 0, 8'h92);

        // Change during conversion: first value committed, then the new one
        result = 16'd100;
        repeat (5) tick();
        result = 16'd200;
        repeat (13) tick();
        check("t5_first_disp", disp_bcd, 20'h00100);
        check("t5_first_busy", busy, 1'b0);
        tick();
        check("t5_rebusy", busy, 1'b1);
        repeat (16) tick();
        check("t5_hold_disp", disp_bcd, 20'h00100);
        tick();
        check("t5_second_disp", disp_bcd, 20'h00200);
        check_digit("t5_d2", 2, 8'hA4);
        check_digit("t5_d1", 1, 8'hC0);

        // Scan walk with SCAN_DIV=4
        prev  = an;
        moved = 1'b0;
        for (int i = 0; i < 10 && !moved; i++) begin
            tick();
            if (an != prev) moved = 1'b1;
        end
        check("scan_sync", moved, 1'b1);
        for (int s = 0; s < 7; s++) begin
            prev = an;
            repeat (3) tick();
            check("scan_hold", an, prev);
            tick();
            check("scan_step", an, {prev[4:0], prev[5]});
        end

        // Reset mid-conversion
        result = 16'd999;
        repeat (5) tick();
        check("t6_busy_pre", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_disp", disp_bcd, 20'h0);
        check("t6_rst_an", an, 6'b111111);
        check("t6_rst_seg", seg, 8'hFF);
        tick();
        rst = 1'b0;
        tick();
        check("t6_restart_busy", busy, 1'b1);
        repeat (17) tick();
        check("t6_restart_disp", disp_bcd, 20'h00999);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
